oam_dma: RTL and testbench

//  Sprite DMA controller and CPU-bus arbiter. Sits between the 6502 core and the system bus.
//  A CPU write to DMA_REG_ADDR halts the core and hands the bus to this block.
//  It then copies 256 bytes from page {data,8'h00} to OAM_DATA_ADDR as read/write pairs.

---
 rtl/oam_dma.sv | 130 +++++++++++++
 tb/tb_oam_dma.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite DMA controller / CPU bus arbiter: copies one 256-byte page to the OAM data port.
// Define OAM_DMA_ALIGN_EN to add the ALIGN state so every read lands on a get (parity 0) cycle.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_rw,
  output logic        cpu_halt,
  output logic        dma_active
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  latch_q, latch_d;
  logic        cpu_halt_q, cpu_halt_d;
  logic        dma_active_q, dma_active_d;
`ifdef OAM_DMA_ALIGN_EN
  logic        parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      latch_q      <= 8'h00;
      cpu_halt_q   <= 1'b0;
      dma_active_q <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      latch_q      <= latch_d;
      cpu_halt_q   <= cpu_halt_d;
      dma_active_q <= dma_active_d;
`ifdef OAM_DMA_ALIGN_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    latch_d      = latch_q;
    cpu_halt_d   = cpu_halt_q;
    dma_active_d = dma_active_q;
`ifdef OAM_DMA_ALIGN_EN
    parity_d     = ~parity_q;
`endif
    bus_a        = cpu_a;
    bus_d_out    = cpu_d;
    bus_rw       = cpu_rw;

    case (state_q)
      IDLE: begin
        if (!cpu_rw && cpu_a == DMA_REG_ADDR) begin
          page_d       = cpu_d;
          state_d      = HALT;
          cpu_halt_d   = 1'b1;
          dma_active_d = 1'b1;
        end
      end
      HALT: begin
        bus_a     = cpu_a;
        bus_rw    = 1'b1;
        bus_d_out = latch_q;
`ifdef OAM_DMA_ALIGN_EN
        // Insert ALIGN when the following cycle would be a put cycle.
        state_d   = parity_q ? READ : ALIGN;
`else
        state_d   = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        bus_a     = cpu_a;
        bus_rw    = 1'b1;
        bus_d_out = latch_q;
        state_d   = READ;
      end
`endif
      READ: begin
        bus_a     = {page_q, idx_q};
        bus_rw    = 1'b1;
        bus_d_out = latch_q;
        latch_d   = bus_d_in;
        state_d   = WRITE;
      end
      WRITE: begin
        bus_a     = OAM_DATA_ADDR;
        bus_rw    = 1'b0;
        bus_d_out = latch_q;
        if (idx_q == 8'hFF) begin
          state_d      = IDLE;
          cpu_halt_d   = 1'b0;
          dma_active_d = 1'b0;
          idx_d        = 8'h00;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_halt   = cpu_halt_q;
  assign dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: cycle-level transfer model plus directed scenarios.
// Handles both the default build and OAM_DMA_ALIGN_EN.
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_rw;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_rw;
  logic        cpu_halt;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  // Transfer model: m_t counts cycles since the trigger edge while a copy is running.
  bit          m_valid  = 0;
  bit          m_active = 0;
  bit          m_parity = 0;
  bit          m_p      = 0;
  int          m_t      = 0;
  int          m_al     = 0;
  logic [7:0]  m_page   = 8'h00;
  logic [7:0]  m_last   = 8'h00;

  // Bus-side observations
  logic [7:0]  wq[$];
  int          halt_cycles;
  int          first_read_delay;
  logic [15:0] first_read_addr;
  logic [15:0] last_read_addr;
  bit          zero_access;

  // Expected values computed per cycle
  logic [15:0] e_a;
  logic [7:0]  e_d;
  logic        e_rw;
  int          s;

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_a      (cpu_a),
    .cpu_d      (cpu_d),
    .cpu_rw     (cpu_rw),
    .bus_d_in   (bus_d_in),
    .bus_a      (bus_a),
    .bus_d_out  (bus_d_out),
    .bus_rw     (bus_rw),
    .cpu_halt   (cpu_halt),
    .dma_active (dma_active)
  );

  assign bus_d_in = mem[bus_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_rw = rw;
    cpu_a  = a;
    cpu_d  = d;
  endtask

  task automatic resetObs();
    wq.delete();
    halt_cycles      = 0;
    first_read_delay = -1;
    first_read_addr  = 16'h0000;
    last_read_addr   = 16'h0000;
    zero_access      = 0;
  endtask

  task automatic triggerDma(input logic [7:0] page, input int want_parity);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (want_parity >= 0 && int'(m_parity) != want_parity && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    cpu_rw = 1'b0;
    cpu_a  = 16'h4014;
    cpu_d  = page;
    applyStimulus(1'b1, 16'h8000, 8'h00);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (cpu_halt === 1'b1 && n < 700) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cpu_halt !== 1'b0) checkOutput("done_timeout", 1, 0);
    repeat (3) applyStimulus(1'b1, 16'h8000, 8'h00);
  endtask

  function automatic int orderErrors(input int base_xor);
    int bad;
    bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] != 8'(i ^ base_xor)) bad++;
    return bad;
  endfunction

  // Model advances on each rising edge using the inputs sampled there.
  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_parity = 0;
      m_t      = 0;
      m_al     = 0;
      m_page   = 8'h00;
      m_last   = 8'h00;
    end else if (m_valid) begin
      m_p      = m_parity;
      m_parity = ~m_parity;
      if (!m_active) begin
        if (cpu_rw == 1'b0 && cpu_a == 16'h4014) begin
          m_active = 1;
          m_page   = cpu_d;
          m_t      = 0;
`ifdef OAM_DMA_ALIGN_EN
          m_al     = m_p ? 1 : 0;
`else
          m_al     = 0;
`endif
        end
      end else begin
        if (m_t >= 1 + m_al && ((m_t - 1 - m_al) % 2) == 0)
          m_last = mem[{m_page, 8'((m_t - 1 - m_al) / 2)}];
        m_t++;
        if (m_t == 1 + m_al + 512) m_active = 0;
      end
    end
  end

  // Compare and observe mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      if (!m_active) begin
        e_a = cpu_a; e_d = cpu_d; e_rw = cpu_rw;
      end else if (m_t < 1 + m_al) begin
        e_a = cpu_a; e_d = m_last; e_rw = 1'b1;
      end else begin
        s = m_t - 1 - m_al;
        if ((s % 2) == 0) begin
          e_a = {m_page, 8'(s / 2)}; e_d = m_last; e_rw = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
          checkOutput("read_parity", int'(m_parity), 0);
`endif
        end else begin
          e_a = 16'h2004; e_d = mem[{m_page, 8'(s / 2)}]; e_rw = 1'b0;
        end
      end
      checkOutput("bus_a",      int'(bus_a),      int'(e_a));
      checkOutput("bus_d_out",  int'(bus_d_out),  int'(e_d));
      checkOutput("bus_rw",     int'(bus_rw),     int'(e_rw));
      checkOutput("cpu_halt",   int'(cpu_halt),   int'(m_active));
      checkOutput("dma_active", int'(dma_active), int'(m_active));

      if (cpu_halt) halt_cycles++;
      if (dma_active && !bus_rw && bus_a == 16'h2004) wq.push_back(bus_d_out);
      if (dma_active && bus_rw && bus_a != cpu_a) begin
        if (first_read_delay < 0) begin
          first_read_delay = halt_cycles - 1;
          first_read_addr  = bus_a;
        end
        last_read_addr = bus_a;
      end
      if (dma_active && bus_a == 16'h0000) zero_access = 1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0300 + i] = 8'(i ^ 8'h5A);
      mem[16'h0700 + i] = 8'hC3;
      mem[16'hFF00 + i] = 8'(i ^ 8'hFF);
    end
    mem[0] = 8'hEE;
    rst = 1'b1; cpu_rw = 1'b1; cpu_a = 16'h0000; cpu_d = 8'h00;
    resetObs();

    // Reset and zero-latency pass-through
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_cpu_halt", int'(cpu_halt), 0);
    checkOutput("rst_dma_active", int'(dma_active), 0);
    cpu_a = 16'h1234;
    #1;
    checkOutput("pass_bus_a", int'(bus_a), 32'h1234);
    checkOutput("pass_bus_rw", int'(bus_rw), 1);
    applyStimulus(1'b1, 16'h8000, 8'h00);

    // Page 03 copy triggered on a get cycle
    resetObs();
    triggerDma(8'h03, 0);
    waitDone();
    checkOutput("t2_writes", wq.size(), 256);
    checkOutput("t2_first", int'(wq[0]), 32'h5A);
    checkOutput("t2_last", int'(wq[255]), 32'hA5);
    checkOutput("t2_order_bad", orderErrors(8'h5A), 0);
    checkOutput("t2_halt_cycles", halt_cycles, 513);
    checkOutput("t2_first_read_delay", first_read_delay, 1);
    checkOutput("t2_first_read_addr", int'(first_read_addr), 32'h0300);

    // Trigger on a put cycle
    resetObs();
    triggerDma(8'h03, 1);
    waitDone();
`ifdef OAM_DMA_ALIGN_EN
    checkOutput("t3_halt_cycles", halt_cycles, 514);
    checkOutput("t3_first_read_delay", first_read_delay, 2);
`else
    checkOutput("t3_halt_cycles", halt_cycles, 513);
    checkOutput("t3_first_read_delay", first_read_delay, 1);
`endif
    checkOutput("t3_writes", wq.size(), 256);

    // Top page, then confirm idx restarted at 0
    resetObs();
    triggerDma(8'hFF, -1);
    waitDone();
    checkOutput("t4_last_read", int'(last_read_addr), 32'hFFFF);
    checkOutput("t4_zero_access", int'(zero_access), 0);
    checkOutput("t4_writes", wq.size(), 256);
    checkOutput("t4_last_data", int'(wq[255]), 32'h00);
    resetObs();
    triggerDma(8'h03, -1);
    waitDone();
    checkOutput("t4_restart_addr", int'(first_read_addr), 32'h0300);

    // Reset during the WRITE of idx 0x40
    resetObs();
    triggerDma(8'h03, -1);
    n = 0;
    while (!(m_active && m_t == 1 + m_al + 2 * 8'h40 + 1) && n < 700) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 700) checkOutput("t5_reach_timeout", 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t5_cpu_halt", int'(cpu_halt), 0);
    checkOutput("t5_dma_active", int'(dma_active), 0);
    repeat (20) applyStimulus(1'b1, 16'h8000, 8'h00);
    checkOutput("t5_writes_frozen", wq.size(), 65);
    resetObs();
    triggerDma(8'h03, -1);
    waitDone();
    checkOutput("t5_restart_addr", int'(first_read_addr), 32'h0300);
    checkOutput("t5_restart_writes", wq.size(), 256);

    // Re-trigger writes during an active copy are ignored
    resetObs();
    triggerDma(8'h03, -1);
    repeat (40) applyStimulus(1'b1, 16'h8000, 8'h00);
    repeat (6) applyStimulus(1'b0, 16'h4014, 8'h07);
    applyStimulus(1'b1, 16'h8000, 8'h00);
    waitDone();
    checkOutput("t6_writes", wq.size(), 256);
    checkOutput("t6_order_bad", orderErrors(8'h5A), 0);
    checkOutput("t6_last_read", int'(last_read_addr), 32'h03FF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
